// File: rtl/reg_file_pkg.sv
// Shared constants, sizing helper and types for the reg_file_sb register file.
package reg_file_pkg;

  localparam int REGF_W  = 16;
  localparam int REGF_D  = 4;
  localparam int REGF_NR = 2;

  // Bits needed to count from 0 up to n_regs inclusive.
  function automatic int cnt_width(input int n_regs);
    return $clog2(n_regs) + 1;
  endfunction

  typedef logic [2**REGF_D-1:0] busy_vec_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: set/clear/flush priority, running busy count,
// Full flag and a combinational busy lookup for every read port.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int D  = REGF_D,
  parameter int NR = REGF_NR
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          set_i,
  input  logic [D-1:0]                  set_reg_i,
  input  logic                          clr_i,
  input  logic [D-1:0]                  clr_reg_i,
  input  logic                          flush_i,
  input  logic [NR*D-1:0]               rd_addr_i,
  output logic [NR-1:0]                 rd_busy_o,
  output logic [cnt_width(2**D)-1:0]    count_o,
  output logic                          full_o
);

  localparam int N  = 2**D;
  localparam int CW = cnt_width(N);

  logic [N-1:0]  busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic          set_v, clr_v, inc, dec;

  // NOTE: every signal driven here is given a value before any branch, so no latch is inferred.
  always_comb begin
    set_v  = set_i && (set_reg_i != '0);
    clr_v  = clr_i && (clr_reg_i != '0);
    busy_d = busy_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      // Set is applied after clear so the new producer wins on a shared register.
      if (clr_v) busy_d[clr_reg_i] = 1'b0;
      if (set_v) busy_d[set_reg_i] = 1'b1;
      inc = set_v && !busy_q[set_reg_i];
      dec = clr_v && busy_q[clr_reg_i] && !(set_v && (set_reg_i == clr_reg_i));
    end
    count_d = flush_i ? '0 : count_q + CW'(inc) - CW'(dec);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NR; i++) begin
      rd_busy_o[i] = busy_q[rd_addr_i[i*D +: D]];
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(N - 1));

endmodule

// File: rtl/reg_file_sb.sv
// Register file with NR combinational read ports, one write port and a busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W  = REGF_W,
  parameter int D  = REGF_D,
  parameter int NR = REGF_NR
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [D-1:0]      writeReg,
  input  logic [W-1:0]      writeValue,
  input  logic [NR*D-1:0]   srcAddr,
  output logic [NR*W-1:0]   ReadData,
  output logic [NR-1:0]     ReadBusy,
  input  logic              BusySet,
  input  logic [D-1:0]      BusyReg,
  input  logic              Flush,
  output logic [D:0]        BusyCount,
  output logic              Full
);

  logic [W-1:0]  regs_q [2**D];
  logic [NR-1:0] sb_busy;

  // NOTE: the data array is asynchronously reset because every register must read 0 during Reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 2**D; r++) regs_q[r] <= '0;
    end else if (RegWrite && (writeReg != '0)) begin
      regs_q[writeReg] <= writeValue;
    end
  end

  reg_scoreboard #(.D(D), .NR(NR)) u_sb (
    .clk_i     (CLK),
    .rst_i     (Reset),
    .set_i     (BusySet),
    .set_reg_i (BusyReg),
    .clr_i     (RegWrite),
    .clr_reg_i (writeReg),
    .flush_i   (Flush),
    .rd_addr_i (srcAddr),
    .rd_busy_o (sb_busy),
    .count_o   (BusyCount),
    .full_o    (Full)
  );

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [D-1:0] addr;
    logic [W-1:0] stored;
    assign addr   = srcAddr[i*D +: D];
    assign stored = (addr == '0) ? '0 : regs_q[addr];
`ifdef REG_FILE_BYPASS_EN
    logic hit;
    // Forwarding is suppressed under Reset so every output still reads 0.
    assign hit = RegWrite && !Reset && (addr != '0) && (writeReg == addr);
    assign ReadData[i*W +: W] = hit ? writeValue : stored;
    assign ReadBusy[i]        = hit ? (BusySet && (BusyReg == writeReg)) : sb_busy[i];
`else
    assign ReadData[i*W +: W] = stored;
    assign ReadBusy[i]        = sb_busy[i];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (W=16, D=4, NR=2).
module tb_reg_file_sb;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        RegWrite;
  logic [3:0]  writeReg;
  logic [15:0] writeValue;
  logic [7:0]  srcAddr;
  logic [31:0] ReadData;
  logic [1:0]  ReadBusy;
  logic        BusySet;
  logic [3:0]  BusyReg;
  logic        Flush;
  logic [4:0]  BusyCount;
  logic        Full;

  int total = 0;
  int bad   = 0;

  reg_file_sb #(.W(16), .D(4), .NR(2)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .writeReg   (writeReg),
    .writeValue (writeValue),
    .srcAddr    (srcAddr),
    .ReadData   (ReadData),
    .ReadBusy   (ReadBusy),
    .BusySet    (BusySet),
    .BusyReg    (BusyReg),
    .Flush      (Flush),
    .BusyCount  (BusyCount),
    .Full       (Full)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] rd(input int p);
    return (p == 0) ? ReadData[15:0] : ReadData[31:16];
  endfunction

  task automatic idle();
    RegWrite = 1'b0; writeReg = '0; writeValue = '0;
    BusySet = 1'b0; BusyReg = '0; Flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
    srcAddr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle(); srcAddr = 8'h53;
    #2;
    total++; if (BusyCount !== 5'd0 || Full !== 1'b0) begin bad++;
      $display("FAIL reset_state: count=%0d full=%0b want 0/0", BusyCount, Full); end
    total++; if (ReadData !== 32'h0 || ReadBusy !== 2'b00) begin bad++;
      $display("FAIL reset_read: data=%h busy=%b want 0/0", ReadData, ReadBusy); end
    @(negedge CLK); Reset = 1'b0;
    RegWrite = 1'b1; writeReg = 4'd3; writeValue = 16'h1234;
    BusySet = 1'b1; BusyReg = 4'd5;
    tick();
    set_rd(4'd3, 4'd5);
    total++; if (rd(0) !== 16'h1234 || ReadBusy[1] !== 1'b1 || BusyCount !== 5'd1) begin bad++;
      $display("FAIL pre_reset: r3=%h busy5=%b cnt=%0d want 1234/1/1", rd(0), ReadBusy[1], BusyCount); end
    Reset = 1'b1;
    #1;
    total++; if (rd(0) !== 16'h0 || ReadBusy[1] !== 1'b0 || BusyCount !== 5'd0) begin bad++;
      $display("FAIL midcycle_reset: r3=%h busy5=%b cnt=%0d want 0/0/0", rd(0), ReadBusy[1], BusyCount); end
    #1; Reset = 1'b0;
    RegWrite = 1'b1; writeReg = 4'd3; writeValue = 16'h4321;
    tick();
    total++; if (rd(0) !== 16'h4321) begin bad++;
      $display("FAIL post_reset_edge: r3=%h want 4321", rd(0)); end
  endtask

  task automatic test_r0_write();
    RegWrite = 1'b1; writeReg = 4'd0; writeValue = 16'hBEEF;
    BusySet = 1'b1; BusyReg = 4'd0;
    tick();
    set_rd(4'd0, 4'd0);
    total++; if (rd(0) !== 16'h0 || ReadBusy !== 2'b00 || BusyCount !== 5'd0) begin bad++;
      $display("FAIL r0_write: r0=%h busy=%b cnt=%0d want 0/0/0", rd(0), ReadBusy, BusyCount); end
  endtask

  task automatic test_busy_then_write();
    int busy_bad;
    set_rd(4'd7, 4'd0);
    BusySet = 1'b1; BusyReg = 4'd7;
    tick();
    busy_bad = 0;
    for (int c = 1; c <= 2; c++) begin
      if (ReadBusy[0] !== 1'b1 || BusyCount !== 5'd1) busy_bad++;
      if (c < 2) tick();
    end
    total++; if (busy_bad != 0) begin bad++;
      $display("FAIL r7_busy_window: %0d bad cycles want 0", busy_bad); end
    RegWrite = 1'b1; writeReg = 4'd7; writeValue = 16'h00A5;
    tick();
    total++; if (ReadBusy[0] !== 1'b0 || BusyCount !== 5'd0 || rd(0) !== 16'h00A5) begin bad++;
      $display("FAIL r7_writeback: busy=%b cnt=%0d data=%h want 0/0/00a5", ReadBusy[0], BusyCount, rd(0)); end
    RegWrite = 1'b1; writeReg = 4'd7; writeValue = 16'h0077;
    tick();
    total++; if (ReadBusy[0] !== 1'b0 || BusyCount !== 5'd0 || rd(0) !== 16'h0077) begin bad++;
      $display("FAIL nonbusy_write: busy=%b cnt=%0d data=%h want 0/0/0077", ReadBusy[0], BusyCount, rd(0)); end
  endtask

  task automatic test_same_edge();
    set_rd(4'd2, 4'd6);
    BusySet = 1'b1; BusyReg = 4'd2;
    tick();
    BusySet = 1'b1; BusyReg = 4'd2;
    RegWrite = 1'b1; writeReg = 4'd2; writeValue = 16'h0F0F;
    tick();
    total++; if (rd(0) !== 16'h0F0F || ReadBusy[0] !== 1'b1 || BusyCount !== 5'd1) begin bad++;
      $display("FAIL same_reg_busy: r2=%h busy=%b cnt=%0d want 0f0f/1/1", rd(0), ReadBusy[0], BusyCount); end
    BusySet = 1'b1; BusyReg = 4'd6;
    RegWrite = 1'b1; writeReg = 4'd2; writeValue = 16'h1111;
    tick();
    total++; if (ReadBusy !== 2'b10 || BusyCount !== 5'd1 || rd(0) !== 16'h1111) begin bad++;
      $display("FAIL diff_regs: busy=%b cnt=%0d r2=%h want 10/1/1111", ReadBusy, BusyCount, rd(0)); end
    set_rd(4'd8, 4'd6);
    BusySet = 1'b1; BusyReg = 4'd8;
    RegWrite = 1'b1; writeReg = 4'd8; writeValue = 16'h8888;
    tick();
    total++; if (ReadBusy !== 2'b11 || BusyCount !== 5'd2 || rd(0) !== 16'h8888) begin bad++;
      $display("FAIL same_reg_idle: busy=%b cnt=%0d r8=%h want 11/2/8888", ReadBusy, BusyCount, rd(0)); end
  endtask

  task automatic test_full_flush();
    Flush = 1'b1;
    tick();
    total++; if (BusyCount !== 5'd0 || ReadBusy !== 2'b00) begin bad++;
      $display("FAIL flush_clear: cnt=%0d busy=%b want 0/00", BusyCount, ReadBusy); end
    for (int r = 1; r <= 14; r++) begin
      BusySet = 1'b1; BusyReg = 4'(r);
      tick();
    end
    total++; if (BusyCount !== 5'd14 || Full !== 1'b0) begin bad++;
      $display("FAIL almost_full: cnt=%0d full=%b want 14/0", BusyCount, Full); end
    BusySet = 1'b1; BusyReg = 4'd15;
    tick();
    total++; if (BusyCount !== 5'd15 || Full !== 1'b1) begin bad++;
      $display("FAIL full: cnt=%0d full=%b want 15/1", BusyCount, Full); end
    BusySet = 1'b1; BusyReg = 4'd3;
    tick();
    total++; if (BusyCount !== 5'd15 || Full !== 1'b1) begin bad++;
      $display("FAIL set_when_full: cnt=%0d full=%b want 15/1", BusyCount, Full); end
    set_rd(4'd4, 4'd10);
    Flush = 1'b1; BusySet = 1'b1; BusyReg = 4'd4;
    RegWrite = 1'b1; writeReg = 4'd10; writeValue = 16'hCAFE;
    tick();
    total++; if (BusyCount !== 5'd0 || Full !== 1'b0 || ReadBusy !== 2'b00 || rd(1) !== 16'hCAFE) begin bad++;
      $display("FAIL flush_prio: cnt=%0d full=%b busy=%b r10=%h want 0/0/00/cafe", BusyCount, Full, ReadBusy, rd(1)); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_pre;
    RegWrite = 1'b1; writeReg = 4'd9; writeValue = 16'h1111;
    tick();
    set_rd(4'd0, 4'd9);
    RegWrite = 1'b1; writeReg = 4'd9; writeValue = 16'h5555;
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_pre = 16'h5555;
`else
    exp_pre = 16'h1111;
`endif
    total++; if (rd(1) !== exp_pre || ReadBusy[1] !== 1'b0) begin bad++;
      $display("FAIL bypass_pre_edge: r9=%h busy=%b want %h/0", rd(1), ReadBusy[1], exp_pre); end
    tick();
    total++; if (rd(1) !== 16'h5555) begin bad++;
      $display("FAIL bypass_post_edge: r9=%h want 5555", rd(1)); end
  endtask

  initial begin
    test_reset();
    test_r0_write();
    test_busy_then_write();
    test_same_edge();
    test_full_flush();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
